// File: rtl/boundary_scan_chain_output_pkg.sv
// Shared definitions for the boundary-scan chains of the ripple-adder wrapper:
// chain geometry helpers and the shift-stage priority encoding that both the
// output chain and the input chain's single-clock rework resolve the same way.
package bscan_pkg;

    // Shift-stage action selected on a TCK edge
    typedef enum logic [1:0] {
        SH_HOLD    = 2'd0,
        SH_RESET   = 2'd1,
        SH_SHIFT   = 2'd2,
        SH_CAPTURE = 2'd3
    } sh_op_e;

    // First sum cell sits right after TDI
    localparam int SUM_BASE = 0;

    // Number of cells in an output chain for an n-bit adder (sum bits + cout)
    function automatic int chain_len(input int n);
        return n + 1;
    endfunction

    // Cell index of the carry-out cell, the last cell before TDO
    function automatic int cout_idx(input int n);
        return n;
    endfunction

    // Shift-stage priority: reset, then shift, then capture, else hold.
    // Shift beating capture keeps an illegal TAP combination deterministic.
    function automatic sh_op_e sh_op(input logic trst,
                                     input logic shift,
                                     input logic capture);
        sh_op_e op;
        if (trst) begin
            op = SH_RESET;
        end else if (shift) begin
            op = SH_SHIFT;
        end else if (capture) begin
            op = SH_CAPTURE;
        end else begin
            op = SH_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/boundary_scan_chain_output_if.sv
// Bus between the TAP/core side and the output boundary-scan chain: serial
// data, DR strobes, EXTEST mode, core results and device pins.
interface boundary_scan_chain_output_if #(
    parameter int N = 16
);
    logic         TDI;
    logic         CaptureDR;
    logic         ShiftDR;
    logic         UpdateDR;
    logic         Mode;
    logic [N-1:0] module_pin_sum;
    logic         module_pin_cout;
    logic [N-1:0] sys_pin_sum;
    logic         sys_pin_cout;
    logic         TDO;

    // TAP controller / core side
    modport master (
        output TDI, CaptureDR, ShiftDR, UpdateDR, Mode,
        output module_pin_sum, module_pin_cout,
        input  sys_pin_sum, sys_pin_cout, TDO
    );

    // Scan chain side
    modport slave (
        input  TDI, CaptureDR, ShiftDR, UpdateDR, Mode,
        input  module_pin_sum, module_pin_cout,
        output sys_pin_sum, sys_pin_cout, TDO
    );
endinterface

// File: rtl/boundary_scan_chain_output_cell.sv
// One output boundary-scan cell: a shift flop, an update flop and the pin
// mux selecting between the core value and the update flop.
module boundary_scan_output_cell
    import bscan_pkg::*;
(
    input  logic clk,
    input  logic trst,
    input  logic scan_in,
    input  logic capture_dr,
    input  logic shift_dr,
    input  logic update_dr,
    input  logic mode,
    input  logic core_in,
    output logic scan_out,
    output logic pin_out
);
    logic   sh_r;
    logic   up_r;
    logic   sh_next_s;
    sh_op_e op_s;

    assign op_s = sh_op(trst, shift_dr, capture_dr);

    // Resolve the next shift-stage value from the prioritised action
    always_comb begin
        sh_next_s = sh_r;
        case (op_s)
            SH_RESET:   sh_next_s = 1'b0;
            SH_SHIFT:   sh_next_s = scan_in;
            SH_CAPTURE: sh_next_s = core_in;
            SH_HOLD:    sh_next_s = sh_r;
            default:    sh_next_s = sh_r;
        endcase
    end

    // Shift-stage flop
    always_ff @(posedge clk) begin
        sh_r <= sh_next_s;
    end

    // Update-stage flop; loads the shift value as it stood before this edge
    always_ff @(posedge clk) begin
        if (trst) begin
            up_r <= 1'b0;
        end else if (update_dr) begin
            up_r <= sh_r;
        end else begin
            up_r <= up_r;
        end
    end

    // Pin mux: EXTEST drives the pin from the update stage, else transparent
    always_comb begin
        if (mode) begin
            pin_out = up_r;
        end else begin
            pin_out = core_in;
        end
    end

    assign scan_out = sh_r;

endmodule

// File: rtl/boundary_scan_chain_output.sv
// Output-side boundary-scan register of the ripple-adder JTAG wrapper.
// Cell order from TDI: sum[0] .. sum[N-1], cout, then TDO.
module boundary_scan_chain_output
    import bscan_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                          TCK,
    input  logic                          TRST,
    boundary_scan_chain_output_if.slave   bus
);
    localparam int LEN      = chain_len(N);
    localparam int COUT_IDX = cout_idx(N);

    logic [LEN-1:0] chain_s;     // shift-stage outputs, cell k at bit k
    logic [LEN-1:0] scan_in_s;   // serial input of each cell
    logic [N-1:0]   pin_sum_s;
    logic           pin_cout_s;

    assign scan_in_s = {chain_s[LEN-2:0], bus.TDI};

    for (genvar i = 0; i < N; i++) begin : g_sum
        boundary_scan_output_cell u_cell (
            .clk        (TCK),
            .trst       (TRST),
            .scan_in    (scan_in_s[SUM_BASE + i]),
            .capture_dr (bus.CaptureDR),
            .shift_dr   (bus.ShiftDR),
            .update_dr  (bus.UpdateDR),
            .mode       (bus.Mode),
            .core_in    (bus.module_pin_sum[i]),
            .scan_out   (chain_s[SUM_BASE + i]),
            .pin_out    (pin_sum_s[i])
        );
    end

    boundary_scan_output_cell u_cout_cell (
        .clk        (TCK),
        .trst       (TRST),
        .scan_in    (scan_in_s[COUT_IDX]),
        .capture_dr (bus.CaptureDR),
        .shift_dr   (bus.ShiftDR),
        .update_dr  (bus.UpdateDR),
        .mode       (bus.Mode),
        .core_in    (bus.module_pin_cout),
        .scan_out   (chain_s[COUT_IDX]),
        .pin_out    (pin_cout_s)
    );

    assign bus.sys_pin_sum  = pin_sum_s;
    assign bus.sys_pin_cout = pin_cout_s;
    assign bus.TDO          = chain_s[COUT_IDX];

endmodule

// File: tb/tb_boundary_scan_chain_output.sv
// Directed, table-driven bench for the output boundary-scan chain (N=16).
module tb_boundary_scan_chain_output;

    logic tck;
    logic trst;
    int   n_vec;
    int   n_bad;

    boundary_scan_chain_output_if #(.N(16)) bus ();

    boundary_scan_chain_output #(.N(16)) dut (
        .TCK  (tck),
        .TRST (trst),
        .bus  (bus.slave)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    typedef struct {
        logic        trst;
        logic        cap;
        logic        shf;
        logic        upd;
        logic        mode;
        logic        tdi;
        logic [15:0] sum;
        logic        cout;
        logic [15:0] esum;
        logic        ecout;
        logic        etdo;
    } vec_t;

    vec_t tbl[19];

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [15:0] esum,
                              input logic ecout, input logic etdo);
        check({name, "_sum"},  {16'd0, bus.sys_pin_sum},  {16'd0, esum});
        check({name, "_cout"}, {31'd0, bus.sys_pin_cout}, {31'd0, ecout});
        check({name, "_tdo"},  {31'd0, bus.TDO},          {31'd0, etdo});
    endtask

    task automatic clear_strobes();
        bus.ShiftDR   = 1'b0;
        bus.CaptureDR = 1'b0;
        bus.UpdateDR  = 1'b0;
    endtask

    initial begin
        logic [15:0] cap_pat;
        logic [15:0] in_pat;
        n_vec = 0;
        n_bad = 0;
        cap_pat = 16'hA5C3;
        in_pat  = 16'h1234;

        trst = 1'b0;
        bus.TDI = 1'b0;
        bus.Mode = 1'b0;
        bus.module_pin_sum = 16'h0000;
        bus.module_pin_cout = 1'b0;
        clear_strobes();

        // Row 0: reset with EXTEST on and core all ones -> pins and TDO zero
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b0};
        // Row 1: transparent mode, pins follow the core
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        // Row 2: capture A5C3/cout=1, cout visible at TDO on the capture edge
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 1'b1, 16'hA5C3, 1'b1, 1'b1};
        // Rows 3..18: shift out, TDO shows sum[15] down to sum[0]; pins stay 0 in EXTEST
        for (int j = 1; j <= 16; j++) begin
            tbl[2 + j] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hA5C3, 1'b1,
                           16'h0000, 1'b0, cap_pat[16 - j]};
        end

        for (int i = 0; i < 19; i++) begin
            trst                = tbl[i].trst;
            bus.CaptureDR       = tbl[i].cap;
            bus.ShiftDR         = tbl[i].shf;
            bus.UpdateDR        = tbl[i].upd;
            bus.Mode            = tbl[i].mode;
            bus.TDI             = tbl[i].tdi;
            bus.module_pin_sum  = tbl[i].sum;
            bus.module_pin_cout = tbl[i].cout;
            tick();
            check_outs($sformatf("tbl%0d", i), tbl[i].esum, tbl[i].ecout, tbl[i].etdo);
        end
        trst = 1'b0;
        clear_strobes();

        // Shift in cout=0 first, then sum[15]..sum[0] of 1234; pins hold during shift
        bus.Mode = 1'b1;
        bus.ShiftDR = 1'b1;
        for (int m = 1; m <= 17; m++) begin
            bus.TDI = (m == 1) ? 1'b0 : in_pat[17 - m];
            tick();
            check($sformatf("shin%0d_sum", m), {16'd0, bus.sys_pin_sum}, 32'd0);
        end
        bus.ShiftDR = 1'b0;
        check("shin_tdo", {31'd0, bus.TDO}, 32'd0);
        bus.UpdateDR = 1'b1;
        tick();
        bus.UpdateDR = 1'b0;
        check("upd_sum",  {16'd0, bus.sys_pin_sum},  32'h0000_1234);
        check("upd_cout", {31'd0, bus.sys_pin_cout}, 32'd0);

        // Transparency and same-cycle Mode switching
        bus.Mode = 1'b0;
        bus.module_pin_sum = 16'h00FF;
        bus.module_pin_cout = 1'b1;
        #1;
        check_outs("transp", 16'h00FF, 1'b1, 1'b0);
        bus.Mode = 1'b1;
        #1;
        check_outs("extest", 16'h1234, 1'b0, 1'b0);

        // Shift + capture together: shift wins, TDO gets old sum[15]=0, not cout=1
        bus.module_pin_sum = 16'hA5C3;
        bus.module_pin_cout = 1'b1;
        bus.TDI = 1'b1;
        bus.ShiftDR = 1'b1;
        bus.CaptureDR = 1'b1;
        tick();
        clear_strobes();
        check("shcap_tdo", {31'd0, bus.TDO}, 32'd0);

        // Shift + update together: update sees pre-shift {cout=0, sum=2469}
        bus.TDI = 1'b0;
        bus.ShiftDR = 1'b1;
        bus.UpdateDR = 1'b1;
        tick();
        clear_strobes();
        check_outs("shupd", 16'h2469, 1'b0, 1'b0);

        // Idle edges: everything holds
        for (int k = 0; k < 3; k++) tick();
        check_outs("hold", 16'h2469, 1'b0, 1'b0);

        // Reset mid-shift with strobes active clears both stages
        bus.TDI = 1'b1;
        bus.ShiftDR = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        trst = 1'b1;
        bus.UpdateDR = 1'b1;
        tick();
        trst = 1'b0;
        clear_strobes();
        check_outs("rst_mid", 16'h0000, 1'b0, 1'b0);
        bus.Mode = 1'b0;
        #1;
        check_outs("rst_transp", 16'hA5C3, 1'b1, 1'b0);
        bus.Mode = 1'b1;

        // All-ones refill: TDO stays 0 until edge 17, then 1
        bus.TDI = 1'b1;
        bus.ShiftDR = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            tick();
            check($sformatf("refill%0d_tdo", e), {31'd0, bus.TDO}, (e >= 17) ? 32'd1 : 32'd0);
        end
        clear_strobes();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
